// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one sync-FIFO write port among
// four valid/ready/last producers. One producer owns the port per burst;
// a burst ends on req_last or after BURST_MAX beats, whichever comes first.
module fifo_wr_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_MAX  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3:0]              req_valid,
   input  logic [3:0]              req_last,
   input  logic [4*DATA_WIDTH-1:0] req_data,
   output logic [3:0]              req_ready,
   input  logic                    fifo_full,
   output logic                    fifo_wr_en,
   output logic [DATA_WIDTH-1:0]   fifo_data_w,
   output logic [1:0]              grant_id,
   output logic                    busy
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_MAX - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                 state;
   logic [1:0]             rr_ptr;
   logic [CNT_W-1:0]       beat_cnt;
   logic [1:0]             pick;
   logic [1:0]             cand;
   logic                   any_req;
   logic                   xfer;
   logic                   burst_end;
   logic [DATA_WIDTH-1:0]  slice [4];

   for (genvar g = 0; g < 4; g++) begin : g_slice
      assign slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Rotating priority search: first valid producer at or after rr_ptr.
   always_comb begin
      pick    = rr_ptr;
      cand    = rr_ptr;
      any_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cand = rr_ptr + 2'(k);
         if (!any_req && req_valid[cand]) begin
            pick    = cand;
            any_req = 1'b1;
         end
      end
   end

   // Granted producer sees ready only while the FIFO has room; full blocks the write in-cycle.
   always_comb begin
      req_ready = '0;
      if (state == GRANT) begin
         req_ready[grant_id] = !fifo_full;
      end
      xfer        = (state == GRANT) && req_valid[grant_id] && !fifo_full;
      burst_end   = xfer && (req_last[grant_id] || (beat_cnt == LAST_CNT));
      fifo_wr_en  = xfer;
      fifo_data_w = slice[grant_id];
   end

   // Grant FSM: IDLE picks a producer, GRANT counts beats until last or forced end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= 2'd0;
         grant_id <= 2'd0;
         beat_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_id <= pick;
                  beat_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (xfer) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (burst_end) begin
                     state  <= IDLE;
                     busy   <= 1'b0;
                     rr_ptr <= grant_id + 2'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb (DATA_WIDTH=8, BURST_MAX=4).
module tb_fifo_wr_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_data_w;
   logic [1:0]  grant_id;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   fifo_wr_arb #(.DATA_WIDTH(8), .BURST_MAX(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_last(req_last),
      .req_data(req_data),
      .req_ready(req_ready),
      .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en),
      .fifo_data_w(fifo_data_w),
      .grant_id(grant_id),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int p, input logic [7:0] v);
      req_data[p*8 +: 8] = v;
   endtask

   task automatic chk_idle(input string tag);
      #1;
      chk({tag, "_busy"},  32'(busy),       32'd0);
      chk({tag, "_wr"},    32'(fifo_wr_en), 32'd0);
      chk({tag, "_ready"}, 32'(req_ready),  32'd0);
   endtask

   task automatic chk_xfer(input string tag, input int g, input logic [7:0] d);
      #1;
      chk({tag, "_busy"},  32'(busy),       32'd1);
      chk({tag, "_gid"},   32'(grant_id),   32'(g));
      chk({tag, "_ready"}, 32'(req_ready),  32'(1 << g));
      chk({tag, "_wr"},    32'(fifo_wr_en), 32'd1);
      chk({tag, "_data"},  32'(fifo_data_w), 32'(d));
   endtask

   task automatic chk_stall(input string tag, input int g, input logic [3:0] rdy);
      #1;
      chk({tag, "_busy"},  32'(busy),       32'd1);
      chk({tag, "_gid"},   32'(grant_id),   32'(g));
      chk({tag, "_ready"}, 32'(req_ready),  32'(rdy));
      chk({tag, "_wr"},    32'(fifo_wr_en), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      req_last  = 4'b0000;
      req_data  = 32'd0;
      fifo_full = 1'b0;
      #12;
      // reset state
      chk("rst_busy",  32'(busy),       32'd0);
      chk("rst_gid",   32'(grant_id),   32'd0);
      chk("rst_ready", 32'(req_ready),  32'd0);
      chk("rst_wr",    32'(fifo_wr_en), 32'd0);
      rst_n = 1'b1;

      // producer 2: three-beat burst A1,A2,A3
      tick(); req_valid = 4'b0100; set_data(2, 8'hA1); chk_idle("t1_idle");
      tick(); chk_xfer("t1_b1", 2, 8'hA1);
      tick(); set_data(2, 8'hA2); chk_xfer("t1_b2", 2, 8'hA2);
      tick(); set_data(2, 8'hA3); req_last = 4'b0100; chk_xfer("t1_b3", 2, 8'hA3);
      tick(); req_valid = 4'b0000; req_last = 4'b0000; chk_idle("t1_end");

      // rr_ptr=3: producers 0 and 3 both valid, 3 wins
      tick(); req_valid = 4'b1001; req_last = 4'b1001;
      set_data(0, 8'h10); set_data(3, 8'h13); chk_idle("t1_rr_idle");
      tick(); chk_xfer("t1_rr", 3, 8'h13);

      // all four single-beat: order 0,1,2,3,0 with one bubble between
      set_data(1, 8'h11); set_data(2, 8'h12);
      req_valid = 4'b1111; req_last = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         tick(); chk_idle("t2_bubble");
         tick(); chk_xfer("t2_grant", n % 4, 8'h10 + 8'(n % 4));
      end
      tick(); req_valid = 4'b0000; req_last = 4'b0000; chk_idle("t2_end");

      // producer 1 streams without last; forced end after 4, producer 3 next, then 1 resumes
      tick(); req_valid = 4'b1010; set_data(1, 8'h51); set_data(3, 8'h33);
      req_last = 4'b1000; chk_idle("t3_idle");
      tick(); chk_xfer("t3_b1", 1, 8'h51);
      tick(); set_data(1, 8'h52); chk_xfer("t3_b2", 1, 8'h52);
      tick(); set_data(1, 8'h53); chk_xfer("t3_b3", 1, 8'h53);
      tick(); set_data(1, 8'h54); chk_xfer("t3_b4", 1, 8'h54);
      tick(); set_data(1, 8'h55); chk_idle("t3_forced");
      tick(); chk_xfer("t3_p3", 3, 8'h33);
      tick(); req_valid = 4'b0010; req_last = 4'b0010; chk_idle("t3_bubble");
      tick(); chk_xfer("t3_b5", 1, 8'h55);
      tick(); req_valid = 4'b0000; req_last = 4'b0000; chk_idle("t3_end");

      // producer 0 four beats with fifo_full for 3 cycles after beat 2
      tick(); req_valid = 4'b0001; set_data(0, 8'hC0); chk_idle("t4_idle");
      tick(); chk_xfer("t4_b1", 0, 8'hC0);
      tick(); set_data(0, 8'hC1); chk_xfer("t4_b2", 0, 8'hC1);
      tick(); set_data(0, 8'hC2); fifo_full = 1'b1; chk_stall("t4_full1", 0, 4'b0000);
      tick(); chk_stall("t4_full2", 0, 4'b0000);
      tick(); chk_stall("t4_full3", 0, 4'b0000);
      tick(); fifo_full = 1'b0; chk_xfer("t4_b3", 0, 8'hC2);
      tick(); set_data(0, 8'hC3); req_last = 4'b0001; chk_xfer("t4_b4", 0, 8'hC3);
      tick(); req_valid = 4'b0000; req_last = 4'b0000; chk_idle("t4_end");

      // reset pulsed on beat 2 of producer 1's burst
      tick(); req_valid = 4'b0010; set_data(1, 8'hD0); chk_idle("t5_idle");
      tick(); chk_xfer("t5_b1", 1, 8'hD0);
      tick(); set_data(1, 8'hD1); chk_xfer("t5_b2", 1, 8'hD1);
      rst_n = 1'b0; req_valid = 4'b0000;
      chk_idle("t5_async");
      chk("t5_gid_rst", 32'(grant_id), 32'd0);
      #1 rst_n = 1'b1;
      tick(); req_valid = 4'b0011; req_last = 4'b0001;
      set_data(0, 8'hE0); set_data(1, 8'hD2); chk_idle("t5_post");
      tick(); chk_xfer("t5_p0", 0, 8'hE0);
      tick(); req_valid = 4'b0000; req_last = 4'b0000; chk_idle("t5_end");

      // producer 0 drops valid 5 cycles mid-burst while producer 1 waits
      tick(); req_valid = 4'b0001; set_data(0, 8'hF0); chk_idle("t6_idle");
      tick(); chk_xfer("t6_b1", 0, 8'hF0);
      for (int n = 0; n < 5; n++) begin
         tick(); req_valid = 4'b0010; req_last = 4'b0010; set_data(1, 8'h21);
         chk_stall("t6_hold", 0, 4'b0001);
      end
      tick(); req_valid = 4'b0011; req_last = 4'b0011; set_data(0, 8'hF1);
      chk_xfer("t6_b2", 0, 8'hF1);
      tick(); req_valid = 4'b0010; chk_idle("t6_bubble");
      tick(); chk_xfer("t6_p1", 1, 8'h21);
      tick(); req_valid = 4'b0000; req_last = 4'b0000; chk_idle("t6_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
